// File: rtl/spi_slave.sv
// Mode-0 SPI slave, MSB first, 8-bit words, oversampled in the clk domain.
// Received bytes appear on cmd with a one-cycle cmd_valid; MISO echoes the last byte.
module spi_slave (
  input  logic       clk,
  input  logic       SCK,
  input  logic       SSEL,
  input  logic       MOSI,
  output logic       MISO,
  output logic [7:0] cmd,
  output logic       cmd_valid,
  input  logic       reset
);

  // Handshake: cmd_valid is a single-cycle strobe with no ready; the consumer
  // must take cmd in that cycle. cmd stays stable until the next strobe.

  logic [2:0] sck_q;
  logic [2:0] ssel_q;
  logic [1:0] mosi_q;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] cmd_q, cmd_d;
  logic       valid_q, valid_d;

  logic       sck_rise;
  logic       sck_fall;
  logic       active;
  logic       ssel_start;
  logic       mosi_bit;
  logic       byte_done;
  logic [7:0] rx_byte;

  assign sck_rise   = (sck_q[2:1] == 2'b01);
  assign sck_fall   = (sck_q[2:1] == 2'b10);
  assign active     = ~ssel_q[1];
  assign ssel_start = (ssel_q[2:1] == 2'b10);
  assign mosi_bit   = mosi_q[1];
  assign byte_done  = active && sck_rise && (bitcnt_q == 3'd7);
  assign rx_byte    = {shift_q[6:0], mosi_bit};

  always_comb begin
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    cmd_d    = cmd_q;
    valid_d  = 1'b0;
    if (!active) begin
      bitcnt_d = 3'd0;
      shift_d  = 8'h00;
    end else begin
      if (sck_rise) begin
        shift_d  = rx_byte;
        bitcnt_d = bitcnt_q + 3'd1;
      end
      if (byte_done) begin
        cmd_d   = rx_byte;
        valid_d = 1'b1;
      end
      // A load wins over the shift so the echoed byte starts at its MSB.
      if (ssel_start) begin
        tx_d = cmd_q;
      end else if (byte_done) begin
        tx_d = rx_byte;
      end else if (sck_fall) begin
        tx_d = {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q    <= 3'b000;
      ssel_q   <= 3'b111;
      mosi_q   <= 2'b00;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 8'h00;
      cmd_q    <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      sck_q    <= {sck_q[1:0], SCK};
      ssel_q   <= {ssel_q[1:0], SSEL};
      mosi_q   <= {mosi_q[0], MOSI};
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      cmd_q    <= cmd_d;
      valid_q  <= valid_d;
    end
  end

  assign MISO      = active & tx_q[7];
  assign cmd       = cmd_q;
  assign cmd_valid = valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed scenarios plus random frames, with a byte-level
// reference model feeding a queue that a negedge monitor drains on cmd_valid.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic       SCK;
  logic       SSEL;
  logic       MOSI;
  logic       MISO;
  logic [7:0] cmd;
  logic       cmd_valid;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  int         lat_q[$];
  logic [7:0] model_cmd  = 8'h00;
  bit         ssel_low   = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] mon_exp;
  int         mon_lat;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  spi_slave dut (
    .clk       (clk),
    .SCK       (SCK),
    .SSEL      (SSEL),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .reset     (reset)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected byte and arrive
  // three clk edges after the SCK rise that completed it.
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      check("valid_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_strobe: cmd=%0h with no byte expected", cmd);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_lat = lat_q.pop_front();
        check("cmd_byte", {24'd0, cmd}, {24'd0, mon_exp});
        check("strobe_latency", cyc, mon_lat);
      end
    end
    prev_valid = cmd_valid;
  end

  // Driver: called on a negedge; clocks out n bits of b MSB first. When
  // chk_miso is set, MISO is compared against miso_exp just before each rise.
  task automatic send_bits(input logic [7:0] b, input int n, input bit chk_miso,
                           input logic [7:0] miso_exp);
    for (int i = 0; i < n; i++) begin
      if (chk_miso)
        check($sformatf("miso_bit%0d", i), {31'd0, MISO}, {31'd0, miso_exp[7-i]});
      if (i == 7)
        check("cmd_hold", {24'd0, cmd}, {24'd0, model_cmd});
      MOSI = b[7-i];
      SCK  = 1'b1;
      if (i == 7 && ssel_low) begin
        exp_q.push_back(b);
        lat_q.push_back(cyc + 3);
        model_cmd = b;
      end
      repeat ($urandom_range(2, 4)) @(negedge clk);
      SCK  = 1'b0;
      MOSI = 1'($urandom_range(0, 1));
      repeat ($urandom_range(4, 6)) @(negedge clk);
    end
  endtask

  task automatic frame_begin();
    SSEL     = 1'b0;
    ssel_low = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (2) @(negedge clk);
    SSEL     = 1'b1;
    ssel_low = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_idle();
    check("cmd_after", {24'd0, cmd}, {24'd0, model_cmd});
    check("valid_idle", {31'd0, cmd_valid}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] start_cmd;
    int nb;
    reset = 1'b1;
    SCK   = 1'b0;
    SSEL  = 1'b1;
    MOSI  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cmd", {24'd0, cmd}, 32'd0);
    check("reset_valid", {31'd0, cmd_valid}, 32'd0);
    check("reset_miso", {31'd0, MISO}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // First byte, then a back-to-back byte in the same frame.
    frame_begin();
    send_bits(8'hEA, 8, 1'b1, 8'h00);
    check_idle();
    send_bits(8'h01, 8, 1'b0, 8'h00);
    check_idle();
    frame_end();

    // Partial byte discarded by SSEL going high.
    frame_begin();
    send_bits(8'hC3, 4, 1'b0, 8'h00);
    frame_end();
    check_idle();
    frame_begin();
    send_bits(8'h5A, 8, 1'b1, 8'h01);
    check_idle();
    frame_end();

    // Echo of the previously received byte on MISO.
    frame_begin();
    send_bits(8'hEA, 8, 1'b1, 8'h5A);
    frame_end();
    frame_begin();
    send_bits(8'(($urandom_range(0, 255))), 8, 1'b1, 8'hEA);
    check_idle();
    frame_end();

    // Reset mid-byte.
    frame_begin();
    send_bits(8'h96, 4, 1'b0, 8'h00);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_cmd", {24'd0, cmd}, 32'd0);
    check("midreset_valid", {31'd0, cmd_valid}, 32'd0);
    check("midreset_miso", {31'd0, MISO}, 32'd0);
    model_cmd = 8'h00;
    SSEL      = 1'b1;
    ssel_low  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    frame_begin();
    send_bits(8'h3C, 8, 1'b1, 8'h00);
    check_idle();
    frame_end();

    // SCK activity with SSEL high must be ignored.
    send_bits(8'hFF, 8, 1'b0, 8'h00);
    check_idle();

    // Random frames of 1-3 bytes, sometimes ending with a partial byte.
    for (int f = 0; f < 25; f++) begin
      frame_begin();
      start_cmd = model_cmd;
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) begin
        b = 8'($urandom_range(0, 255));
        send_bits(b, 8, (j == 0), start_cmd);
      end
      if ($urandom_range(0, 3) == 0)
        send_bits(8'($urandom_range(0, 255)), $urandom_range(1, 7), 1'b0, 8'h00);
      check_idle();
      frame_end();
    end

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
